// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: steps one instruction at a time through the
// fetch, decode, execute, memory and writeback stages, and keeps the PC and activity counters.
module multicycle_sequencer #(
    parameter int               WORD        = 64,
    parameter int               CNT_W       = 32,
    parameter int               MEM_TIMEOUT = 16,
    parameter int               SKIP_MEM    = 1,
    parameter logic [WORD-1:0]  RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_mode,
    input  logic              step,
    input  logic              mem_access,
    input  logic              mem_ack,
    input  logic              pc_src,
    input  logic [WORD-1:0]   branch_target,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              wb_en,
    output logic              mem_req,
    output logic              mem_en,
    output logic [WORD-1:0]   cur_pc,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              start_ok;
    logic              use_mem;

    assign start_ok    = run && (!step_mode || step);
    assign use_mem     = mem_access || (SKIP_MEM == 0);
    // The counter holds the number of ack-less cycles before this one, so this is the last allowed cycle.
    assign timeout_hit = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (start_ok) next_state = S_FETCH;
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = S_EXECUTE;
            S_EXECUTE:   next_state = use_mem ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (mem_ack)
                    next_state = S_WRITEBACK;
                else if (timeout_hit)
                    next_state = S_ERROR;
            end
            S_WRITEBACK: next_state = (run && !step_mode) ? S_FETCH : S_IDLE;
            S_ERROR:     next_state = S_ERROR;
            default:     next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cur_pc      <= RESET_PC;
            instr_count <= '0;
            cycle_count <= '0;
            wait_cnt    <= '0;
        end else begin
            state <= next_state;

            if (busy)
                cycle_count <= cycle_count + CNT_W'(1);

            if (state == S_EXECUTE)
                wait_cnt <= '0;
            else if (state == S_MEMORY && !mem_ack)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (state == S_WRITEBACK) begin
                cur_pc      <= pc_src ? branch_target : cur_pc + WORD'(4);
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Everything below is a pure decode of the current state; ERROR can only be left by reset,
    // so deriving timeout_err from it keeps the flag sticky.
    assign fetch_en    = (state == S_FETCH);
    assign decode_en   = (state == S_DECODE);
    assign exec_en     = (state == S_EXECUTE);
    assign wb_en       = (state == S_WRITEBACK);
    assign mem_req     = (state == S_MEMORY);
    assign mem_en      = (state == S_MEMORY) && mem_ack;
    assign busy        = (state != S_IDLE) && (state != S_ERROR);
    assign timeout_err = (state == S_ERROR);

endmodule
